// File: rtl/lstm_mem_pkg.sv
// rtl/lstm_mem_pkg.sv - shared main_mem region map and loader state encoding
package lstm_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IN,
        LOAD_W1,
        LOAD_W2,
        SETTLE,
        RUN
    } loader_state_t;

    localparam int DEF_FEATURES = 4;
    localparam int DEF_CYCLES   = 10;
    localparam int DEF_WEIGHTS  = 64;

    localparam int IN_FIRST    = 0;
    localparam int W1_FIRST    = IN_FIRST + DEF_FEATURES * DEF_CYCLES;
    localparam int W2_FIRST    = W1_FIRST + DEF_WEIGHTS;
    localparam int TOTAL_WORDS = W2_FIRST + DEF_WEIGHTS;

    function automatic int in_region_size(input int features, input int cycles);
        return features * cycles;
    endfunction

    function automatic logic [1:0] region_of(input loader_state_t s);
        case (s)
            LOAD_IN: return 2'd1;
            LOAD_W1: return 2'd2;
            LOAD_W2: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/main_mem_loader_if.sv
// rtl/main_mem_loader_if.sv - host load stream, DMAC write-back and main_mem write port
interface main_mem_loader_if #(
    parameter int ELEMENT_BITS     = 8,
    parameter int MAIN_MEM_ADD_LEN = 11
);
    logic                        s_valid;
    logic [ELEMENT_BITS-1:0]     s_data;
    logic                        s_ready;
    logic                        dmac_we;
    logic [MAIN_MEM_ADD_LEN-1:0] dmac_address;
    logic [ELEMENT_BITS-1:0]     dmac_data;
    logic                        dpr_we;
    logic [MAIN_MEM_ADD_LEN-1:0] dpr_address_in;
    logic [ELEMENT_BITS-1:0]     dpr_data_in;

    modport master (
        output s_valid, s_data, dmac_we, dmac_address, dmac_data,
        input  s_ready, dpr_we, dpr_address_in, dpr_data_in
    );

    modport slave (
        input  s_valid, s_data, dmac_we, dmac_address, dmac_data,
        output s_ready, dpr_we, dpr_address_in, dpr_data_in
    );
endinterface

// File: rtl/main_mem_wr_mux.sv
// rtl/main_mem_wr_mux.sv - selects loader or DMAC as the single main_mem write source
module main_mem_wr_mux #(
    parameter int ELEMENT_BITS     = 8,
    parameter int MAIN_MEM_ADD_LEN = 11
) (
    input  logic                        sel_dmac_i,
    input  logic                        ld_we_i,
    input  logic [MAIN_MEM_ADD_LEN-1:0] ld_addr_i,
    input  logic [ELEMENT_BITS-1:0]     ld_data_i,
    input  logic                        dmac_we_i,
    input  logic [MAIN_MEM_ADD_LEN-1:0] dmac_addr_i,
    input  logic [ELEMENT_BITS-1:0]     dmac_data_i,
    output logic                        dpr_we_o,
    output logic [MAIN_MEM_ADD_LEN-1:0] dpr_addr_o,
    output logic [ELEMENT_BITS-1:0]     dpr_data_o
);
    assign dpr_we_o   = sel_dmac_i ? dmac_we_i   : ld_we_i;
    assign dpr_addr_o = sel_dmac_i ? dmac_addr_i : ld_addr_i;
    assign dpr_data_o = sel_dmac_i ? dmac_data_i : ld_data_i;
endmodule

// File: rtl/main_mem_loader.sv
// rtl/main_mem_loader.sv - streams inputs/W1/W2 into main_mem, then hands the port to the DMAC
module main_mem_loader
    import lstm_mem_pkg::*;
#(
    parameter int ELEMENT_BITS     = 8,
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int FEATURES         = 4,
    parameter int CYCLES           = 10,
    parameter int WEIGHTS          = 64,
    parameter int SETTLE_CYCLES    = 2
) (
    input  logic                fpga_clk,
    input  logic                reset_n,
    input  logic                load_go,
    input  logic                abort,
    output logic                start,
    output logic [1:0]          region,
    output logic                load_done,
    output logic                err,
    main_mem_loader_if.slave    bus
);
    localparam int AW      = MAIN_MEM_ADD_LEN;
    localparam int IN_SIZE = in_region_size(FEATURES, CYCLES);
    localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    loader_state_t           state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic                    wr_we_q, wr_we_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [ELEMENT_BITS-1:0] wr_data_q, wr_data_d;
    logic                    load_done_q, load_done_d;
    logic                    err_q, err_d;

    logic          load_phase;
    logic          accept;
    logic [AW-1:0] last_cnt;

    assign load_phase = (state_q == LOAD_IN) || (state_q == LOAD_W1) || (state_q == LOAD_W2);
    assign accept     = load_phase && bus.s_valid;
    assign last_cnt   = (state_q == LOAD_IN) ? AW'(IN_SIZE - 1) : AW'(WEIGHTS - 1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        wr_we_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        load_done_d = 1'b0;
        err_d       = err_q | (bus.dmac_we && (state_q != RUN));

        if (accept) begin
            wr_we_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = bus.s_data;
            ptr_d     = ptr_q + 1'b1;
            cnt_d     = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_go) begin
                    state_d = LOAD_IN;
                    ptr_d   = AW'(IN_FIRST);
                    cnt_d   = '0;
                end
            end
            LOAD_IN, LOAD_W1, LOAD_W2: begin
                // Pointer keeps running across regions; only the beat counter restarts.
                if (accept && (cnt_q == last_cnt)) begin
                    cnt_d = '0;
                    case (state_q)
                        LOAD_IN: state_d = LOAD_W1;
                        LOAD_W1: state_d = LOAD_W2;
                        default: begin
                            state_d  = SETTLE;
                            settle_d = '0;
                        end
                    endcase
                end
            end
            SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A beat accepted on the abort edge is still written via wr_*_d above.
        if (abort && (load_phase || (state_q == SETTLE))) begin
            state_d  = IDLE;
            cnt_d    = '0;
            settle_d = '0;
        end
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            settle_q    <= '0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            wr_we_q     <= wr_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_ready = load_phase;
    assign start       = (state_q == RUN);
    assign region      = region_of(state_q);
    assign load_done   = load_done_q;
    assign err         = err_q;

    main_mem_wr_mux #(
        .ELEMENT_BITS    (ELEMENT_BITS),
        .MAIN_MEM_ADD_LEN(MAIN_MEM_ADD_LEN)
    ) u_wr_mux (
        .sel_dmac_i (state_q == RUN),
        .ld_we_i    (wr_we_q),
        .ld_addr_i  (wr_addr_q),
        .ld_data_i  (wr_data_q),
        .dmac_we_i  (bus.dmac_we),
        .dmac_addr_i(bus.dmac_address),
        .dmac_data_i(bus.dmac_data),
        .dpr_we_o   (bus.dpr_we),
        .dpr_addr_o (bus.dpr_address_in),
        .dpr_data_o (bus.dpr_data_in)
    );
endmodule

// File: tb/tb_main_mem_loader.sv
// tb/tb_main_mem_loader.sv - self-checking bench for main_mem_loader
module tb_main_mem_loader;
    localparam int EB     = 8;
    localparam int AL     = 11;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, load_go, abort;
    logic       start, load_done, err;
    logic [1:0] region;

    main_mem_loader_if #(.ELEMENT_BITS(EB), .MAIN_MEM_ADD_LEN(AL)) bus ();

    main_mem_loader #(
        .ELEMENT_BITS(EB), .MAIN_MEM_ADD_LEN(AL), .FEATURES(4), .CYCLES(10),
        .WEIGHTS(64), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .fpga_clk (clk),
        .reset_n  (reset_n),
        .load_go  (load_go),
        .abort    (abort),
        .start    (start),
        .region   (region),
        .load_done(load_done),
        .err      (err),
        .bus      (bus)
    );

    typedef struct {
        logic [AL-1:0] addr;
        logic [EB-1:0] data;
        int            due;
    } wr_t;

    typedef struct {
        int         beats;
        int         action;
        logic [1:0] region;
        logic       s_ready;
        logic       start;
    } vec_t;

    wr_t  sbq[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_addr = -1;
    int   exp_ptr = 0;
    bit   tog = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (bus.dpr_we === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write addr %0d data %0h expected no write",
                         bus.dpr_address_in, bus.dpr_data_in);
            end else begin
                e = sbq.pop_front();
                chk("sb_cycle", cyc, e.due);
                chk("sb_addr", bus.dpr_address_in, e.addr);
                chk("sb_data", bus.dpr_data_in, e.data);
                last_addr = int'(bus.dpr_address_in);
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missing: got no write expected addr %0d data %0h", e.addr, e.data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        exp_ptr = 0;
        load_go = 1'b1;
        tick();
        load_go = 1'b0;
    endtask

    task automatic send(input int n, input bit gap);
        int  sent;
        wr_t e;
        sent = 0;
        while (sent < n) begin
            if (gap && tog) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = exp_ptr[EB-1:0];
                e.addr = exp_ptr[AL-1:0];
                e.data = exp_ptr[EB-1:0];
                e.due  = cyc + 2;
                sbq.push_back(e);
                exp_ptr++;
                sent++;
            end
            if (gap) tog = ~tog;
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic run_table(input bit gap);
        int done;
        done = 0;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].beats - done, gap);
            done = tbl[i].beats;
            chk($sformatf("vec%0d_region", i), region, tbl[i].region);
            chk($sformatf("vec%0d_s_ready", i), bus.s_ready, tbl[i].s_ready);
            chk($sformatf("vec%0d_start", i), start, tbl[i].start);
            if (gap && tbl[i].action == 1) begin
                tick();
                bus.dmac_we = 1'b1; bus.dmac_address = 11'd168; bus.dmac_data = 8'h5A;
                #1;
                chk("dmac_load_dropped", bus.dpr_we, 1'b0);
                tick();
                bus.dmac_we = 1'b0;
                chk("dmac_load_err", err, 1'b1);
                chk("dmac_load_region", region, 2'd2);
            end
            if (gap && tbl[i].action == 2) begin
                load_go = 1'b1;
                tick();
                load_go = 1'b0;
                chk("go_w2_region", region, 2'd3);
                chk("go_w2_ready", bus.s_ready, 1'b1);
            end
        end
    endtask

    task automatic wait_run(input string tag);
        int k;
        k = 0;
        while (start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_settle_latency"}, k, SETTLE);
        chk({tag, "_load_done_pulse"}, load_done, 1'b1);
        tick();
        chk({tag, "_load_done_clear"}, load_done, 1'b0);
        chk({tag, "_start_held"}, start, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, start, 1'b0);
        chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
        chk({tag, "_region"}, region, 2'd0);
        chk({tag, "_load_done"}, load_done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_dpr_we"}, bus.dpr_we, 1'b0);
        chk({tag, "_dpr_addr"}, bus.dpr_address_in, 0);
        chk({tag, "_dpr_data"}, bus.dpr_data_in, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        wr_t e;
        tbl[0] = '{0,   0, 2'd1, 1'b1, 1'b0};
        tbl[1] = '{1,   0, 2'd1, 1'b1, 1'b0};
        tbl[2] = '{39,  0, 2'd1, 1'b1, 1'b0};
        tbl[3] = '{40,  0, 2'd2, 1'b1, 1'b0};
        tbl[4] = '{41,  1, 2'd2, 1'b1, 1'b0};
        tbl[5] = '{103, 0, 2'd2, 1'b1, 1'b0};
        tbl[6] = '{104, 0, 2'd3, 1'b1, 1'b0};
        tbl[7] = '{120, 2, 2'd3, 1'b1, 1'b0};
        tbl[8] = '{167, 0, 2'd3, 1'b1, 1'b0};
        tbl[9] = '{168, 0, 2'd0, 1'b0, 1'b0};

        reset_n = 1'b0; load_go = 1'b0; abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        bus.dmac_we = 1'b0; bus.dmac_address = '0; bus.dmac_data = '0;
        tick();
        tick();
        chk_zero("reset");
        reset_n = 1'b1;
        tick();
        chk("idle_s_ready", bus.s_ready, 1'b0);

        // Back-to-back load, then RUN behaviour.
        start_load();
        run_table(1'b0);
        wait_run("bb");
        load_go = 1'b1;
        tick();
        load_go = 1'b0;
        chk("run_go_start", start, 1'b1);
        chk("run_go_region", region, 2'd0);
        chk("run_go_load_done", load_done, 1'b0);
        bus.dmac_we = 1'b1; bus.dmac_address = 11'd168; bus.dmac_data = 8'h5A;
        e.addr = 11'd168; e.data = 8'h5A; e.due = cyc + 1;
        sbq.push_back(e);
        #1;
        chk("run_dmac_we", bus.dpr_we, 1'b1);
        chk("run_dmac_addr", bus.dpr_address_in, 11'd168);
        chk("run_dmac_data", bus.dpr_data_in, 8'h5A);
        tick();
        bus.dmac_we = 1'b0;
        chk("run_dmac_no_err", err, 1'b0);

        // Stalled load with DMAC poke in W1 and stray load_go in W2.
        do_reset();
        chk("reset2_err", err, 1'b0);
        tog = 1'b1;
        start_load();
        run_table(1'b1);
        wait_run("gap");
        chk("gap_err_sticky", err, 1'b1);

        // Abort after 50 beats, then a clean reload.
        do_reset();
        chk("reset3_err", err, 1'b0);
        start_load();
        send(50, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_s_ready", bus.s_ready, 1'b0);
        chk("abort_region", region, 2'd0);
        chk("abort_start", start, 1'b0);
        chk("abort_last_addr", last_addr, 49);
        repeat (4) tick();
        chk("abort_no_start", start, 1'b0);
        start_load();
        send(168, 1'b0);
        wait_run("reload");

        // Asynchronous reset in the middle of SETTLE.
        do_reset();
        start_load();
        send(168, 1'b0);
        tick();
        chk("settle_region", region, 2'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk_zero("settle_rst");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("settle_rst_start%0d", i), start, 1'b0);
        end

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_mem_loader.md
MAIN_MEM_LOADER -- requirements
Module: main_mem_loader

Interface
REQ-001 Parameters SHALL be: ELEMENT_BITS, default 8, word width; MAIN_MEM_ADD_LEN, default 11, address width; FEATURES, default 4; CYCLES, default 10; WEIGHTS, default 64; SETTLE_CYCLES, default 2, idle cycles between last load write and start.
REQ-002 fpga_clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 load_go  in  1  one-cycle pulse; begins a load session.
REQ-005 abort  in  1  level; cancels an in-progress load.
REQ-006 s_valid  in  1  host load stream valid.
REQ-007 s_data  in  ELEMENT_BITS  host load word.
REQ-008 s_ready  out  1  loader accepts s_data this cycle.
REQ-009 dmac_we  in  1  DMAC write-back enable.
REQ-010 dmac_address  in  MAIN_MEM_ADD_LEN  DMAC write address.
REQ-011 dmac_data  in  ELEMENT_BITS  DMAC write data.
REQ-012 dpr_we  out  1  main_mem write enable (drives both cs_in and we_in).
REQ-013 dpr_address_in  out  MAIN_MEM_ADD_LEN  main_mem write address.
REQ-014 dpr_data_in  out  ELEMENT_BITS  main_mem write data.
REQ-015 start  out  1  level; system run enable to top/cpu.
REQ-016 region  out  2  0=idle/run, 1=inputs, 2=W1, 3=W2.
REQ-017 load_done  out  1  one-cycle pulse on entry to RUN.
REQ-018 err  out  1  sticky: DMAC write attempted outside RUN.

Function
REQ-019 Region map SHALL be: IN_FIRST=0, size FEATURES*CYCLES (40); W1_FIRST=IN_FIRST+40; W2_FIRST=W1_FIRST+WEIGHTS (104); total 168 words.
REQ-020 FSM states SHALL be IDLE, LOAD_IN, LOAD_W1, LOAD_W2, SETTLE, RUN.
REQ-021 IDLE: s_ready=0, start=0; load_go -> LOAD_IN, address pointer := IN_FIRST, beat counter := 0.
REQ-022 In LOAD_* s_ready SHALL be 1; a beat is accepted when s_valid&&s_ready; stalls (s_valid=0) hold pointer and counter.
REQ-023 Each accepted beat SHALL produce dpr_we=1, dpr_address_in=pointer, dpr_data_in=s_data exactly one cycle later (registered); pointer increments by 1 per beat.
REQ-024 The region's last beat (counter = size-1) SHALL advance LOAD_IN->LOAD_W1->LOAD_W2->SETTLE on the accepting edge; the counter clears, the pointer continues contiguously.
REQ-025 SETTLE SHALL last SETTLE_CYCLES cycles with s_ready=0, then enter RUN.
REQ-026 RUN: start=1, load_done pulses in the first RUN cycle, write port passes dmac_we/dmac_address/dmac_data combinationally; load_go ignored; RUN is left only by reset.
REQ-027 load_go outside IDLE SHALL be ignored.
REQ-028 abort in any LOAD_* or SETTLE SHALL return to IDLE next cycle; a write registered on the abort edge still completes; start never asserts.
REQ-029 dmac_we while not in RUN SHALL be dropped (no dpr_we) and set err; err clears only on reset.
REQ-030 Outside writes, dpr_we=0 and dpr_address_in/dpr_data_in SHALL be 0 in IDLE/SETTLE.

Reset
REQ-031 On reset_n low, immediately: state=IDLE, start=0, s_ready=0, dpr_we=0, dpr_address_in=0, dpr_data_in=0, region=0, load_done=0, err=0, counters=0.
REQ-032 Reset mid-load or mid-RUN SHALL discard progress; a new load_go is required.

Structure
REQ-033 The region base/size constants and the state enum SHALL live in a shared package, lstm_mem_pkg.
REQ-034 The write-port mux SHALL be a sub-module, main_mem_wr_mux (select, two write sources, one dpr output).

Verification
REQ-035 Reset, load_go, 168 back-to-back beats data=i[7:0] -> writes at addresses 0..167 with data i, one-cycle latency, load_done and start at beat 168 + SETTLE_CYCLES + 1 cycles.
REQ-036 s_valid toggled every other cycle -> the same 168 writes, no gaps in addresses, region transitions at beats 40 and 104.
REQ-037 abort after 50 beats -> state IDLE, start=0, last write address 49; subsequent full load completes normally.
REQ-038 dmac_we=1, addr=168, data=8'h5A during LOAD_W1 -> no dpr_we from DMAC, err=1 until reset; same in RUN -> dpr_we=1, addr 168, data 8'h5A same cycle.
REQ-039 load_go pulsed during LOAD_W2 and RUN -> no effect on pointer or state.
REQ-040 reset_n asserted mid-SETTLE -> all outputs zero asynchronously, start never rises.
